// File: rtl/handshake_rx_endpoint.sv
// Receive end of the four-phase req/ack CDC handshake: synchronises the remote
// request, captures the data word into a FWFT FIFO and returns an acknowledge.
module handshake_rx_endpoint #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,   // power of two, >= 2
    parameter int unsigned SYNC_STAGES = 2    // >= 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               reqin,
    input  logic [DATA_WIDTH-1:0]              datain,
    output logic                               ackout,
    output logic [DATA_WIDTH-1:0]              dataout,
    output logic                               outvalid,
    input  logic                               outready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    typedef enum logic [1:0] {
        RIDLE = 2'b00,
        RACK  = 2'b01
    } state_e;

    state_e state_q, state_d;
    logic   ackout_q;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;

    logic push;
    logic pop;
    logic full;

    // reqin goes straight into the first flop; nothing else samples it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], reqin};
        end
    end

    assign req_sync = sync_q[SYNC_STAGES-1];

    // Full uses the registered count, so a same-cycle pop never frees a slot early
    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) && outready;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            RIDLE: begin
                if (req_sync && !full) begin
                    push    = 1'b1;
                    state_d = RACK;
                end
            end
            RACK: begin
                if (!req_sync) begin
                    state_d = RIDLE;
                end
            end
            default: begin
                state_d = RIDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RIDLE;
            ackout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ackout_q <= (state_d == RACK);
        end
    end

    assign ackout = ackout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Registered head word: loads from datain when the incoming word becomes the
    // head, otherwise from the entry behind the one being popped.
    always_comb begin
        head_d = head_q;
        if (push && ((count_q == '0) || (pop && (count_q == ONE_CNT)))) begin
            head_d = datain;
        end else if (pop && (count_q > ONE_CNT)) begin
            head_d = mem[rd_ptr_q + ONE_PTR];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= datain;
        end
    end

    assign dataout    = head_q;
    assign outvalid   = (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_handshake_rx_endpoint.sv
// Self-checking bench for handshake_rx_endpoint: directed scenarios plus random
// traffic, all checked every cycle against a queue-based handshake model.
module tb_handshake_rx_endpoint;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          reqin = 1'b0;
    logic [DW-1:0] datain = '0;
    logic          ackout;
    logic [DW-1:0] dataout;
    logic          outvalid;
    logic          outready = 1'b0;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad   = 0;

    handshake_rx_endpoint #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .reqin     (reqin),
        .datain    (datain),
        .ackout    (ackout),
        .dataout   (dataout),
        .outvalid  (outvalid),
        .outready  (outready),
        .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the request is seen SYNC edges late; one word per handshake
    // while acknowledge is low and there is room; pops whenever ready and non-empty.
    logic [DW-1:0] mq[$];
    logic          m_ack = 1'b0;
    logic          hist[SYNC];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ack = 1'b0;
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
        end else begin
            automatic logic rs   = hist[SYNC-1];
            automatic int   sz   = mq.size();
            automatic logic popm = (sz > 0) && outready;
            automatic logic pshm = !m_ack && rs && (sz < DEPTH);
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = reqin;
            if (popm) void'(mq.pop_front());
            if (pshm) mq.push_back(datain);
            if (pshm) m_ack = 1'b1;
            else if (m_ack && !rs) m_ack = 1'b0;
        end
    end

    always @(negedge clock) begin
        check("ackout", 64'(ackout), 64'(m_ack));
        check("outvalid", 64'(outvalid), 64'(mq.size() != 0));
        check("fifo_count", 64'(fifo_count), 64'(mq.size()));
        if (mq.size() != 0) check("dataout", 64'(dataout), 64'(mq[0]));
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_ack(input logic val);
        int n = 0;
        while (ackout !== val && n < 40) begin
            step();
            n++;
        end
        if (ackout !== val) check("ack_timeout", 64'(ackout), 64'(val));
    endtask

    task automatic xfer(input logic [DW-1:0] d);
        datain = d;
        reqin  = 1'b1;
        wait_ack(1'b1);
        reqin = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic    stop_drv = 1'b0;
    logic    rand_ready = 1'b0;
    int      edges;
    int      peak;
    logic [DW-1:0] got[4];

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        check("reset_dataout", 64'(dataout), 64'h0);
        check("reset_ackout", 64'(ackout), 64'h0);
        check("reset_count", 64'(fifo_count), 64'h0);

        // Single transfer with exact latency
        datain   = 32'hA5A5_0001;
        outready = 1'b1;
        reqin    = 1'b1;
        edges    = 0;
        while (ackout == 1'b0 && edges < 20) begin
            step();
            edges++;
        end
        check("single_latency", 64'(edges), 64'd3);
        check("single_valid", 64'(outvalid), 64'h1);
        check("single_data", 64'(dataout), 64'hA5A5_0001);
        step();
        check("single_popped", 64'(fifo_count), 64'h0);
        repeat (4) step();
        reqin = 1'b0;
        edges = 0;
        while (ackout == 1'b1 && edges < 20) begin
            step();
            edges++;
        end
        check("release_latency", 64'(edges), 64'd3);

        // Long request: one write only
        datain = 32'h0000_1234;
        reqin  = 1'b1;
        peak   = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("long_peak", 64'(peak), 64'd1);
        check("long_ack_held", 64'(ackout), 64'h1);
        reqin = 1'b0;
        wait_ack(1'b0);

        // Backpressure: five handshakes into a four-deep FIFO
        outready = 1'b0;
        for (int i = 1; i <= 4; i++) xfer(DW'(i));
        check("bp_full", 64'(fifo_count), 64'd4);
        datain = 32'd5;
        reqin  = 1'b1;
        repeat (6) step();
        check("bp_ack_held", 64'(ackout), 64'h0);
        check("bp_head", 64'(dataout), 64'd1);
        outready = 1'b1;
        step();
        outready = 1'b0;
        wait_ack(1'b1);
        check("bp_refill", 64'(fifo_count), 64'd4);
        reqin = 1'b0;
        wait_ack(1'b0);
        outready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got[i] = dataout;
            step();
        end
        for (int i = 0; i < 4; i++) check("bp_order", 64'(got[i]), 64'(i + 2));

        // Wrap-around with outready toggling every cycle
        stop_drv = 1'b0;
        fork
            while (!stop_drv) begin
                step();
                outready = ~outready;
            end
        join_none
        for (int i = 0; i < 10; i++) xfer(DW'(i));
        stop_drv = 1'b1;
        step();
        step();
        outready = 1'b1;
        repeat (8) step();
        check("wrap_drained", 64'(fifo_count), 64'h0);

        // Simultaneous push and pop at count 2
        outready = 1'b0;
        xfer(32'hC0DE_0001);
        xfer(32'hC0DE_0002);
        datain = 32'hC0DE_0003;
        reqin  = 1'b1;
        step();
        step();
        outready = 1'b1;
        step();
        outready = 1'b0;
        check("pp_count", 64'(fifo_count), 64'd2);
        check("pp_head", 64'(dataout), 64'hC0DE_0002);
        check("pp_ack", 64'(ackout), 64'h1);
        reqin = 1'b0;
        wait_ack(1'b0);

        // Reset while in RACK with three words buffered
        do_reset();
        xfer(32'hBEEF_0001);
        xfer(32'hBEEF_0002);
        datain = 32'hBEEF_0003;
        reqin  = 1'b1;
        wait_ack(1'b1);
        check("mid_count", 64'(fifo_count), 64'd3);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_ack_drop", 64'(ackout), 64'h0);
        check("mid_valid_drop", 64'(outvalid), 64'h0);
        check("mid_count_drop", 64'(fifo_count), 64'h0);
        step();
        reset = 1'b0;
        wait_ack(1'b1);
        check("mid_recapture", 64'(fifo_count), 64'd1);
        check("mid_recapture_data", 64'(dataout), 64'hBEEF_0003);
        reqin = 1'b0;
        wait_ack(1'b0);

        // Random traffic
        stop_drv = 1'b0;
        fork
            while (!stop_drv) begin
                step();
                outready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) step();
            xfer($urandom);
        end
        stop_drv = 1'b1;
        step();
        step();
        outready = 1'b1;
        repeat (8) step();
        check("rand_drained", 64'(fifo_count), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/handshake_rx_endpoint.md
Name: handshake_rx_endpoint

Overview:
- Standalone receive end of the team's four-phase req/ack clock-domain-crossing handshake.
- Runs entirely in the destination clock domain.
- Synchronises a remote transmitter's request and captures its data word into a small first-word-fall-through FIFO.
- Returns an acknowledge to the transmitter, and presents words to local logic over a valid/ready interface with backpressure to the remote side.

Parameters:
- DATA_WIDTH, 32, width of the transferred word.
- FIFO_DEPTH, 4, number of buffered words; power of two, minimum 2.
- SYNC_STAGES, 2, flops in the reqin synchroniser; minimum 2.

Ports:
- clock  input  1  destination-domain clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- reqin  input  1  request from the remote transmitter; asynchronous to clock.
- datain  input  DATA_WIDTH  remote data; held stable by the transmitter while reqin is high.
- ackout  output  1  acknowledge to the remote transmitter; driven directly from a flop.
- dataout  output  DATA_WIDTH  FIFO head word.
- outvalid  output  1  high when the FIFO is not empty.
- outready  input  1  local consumer accepts dataout this cycle.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of words currently held.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - synchroniser flops = 0, state = RIDLE, ackout = 0.
  - FIFO pointers and count = 0, so outvalid = 0 and fifo_count = 0.
  - dataout = 0; storage contents are not reset.
- Synchroniser: reqin passes through SYNC_STAGES flops to req_sync. No logic touches reqin before the first flop.
- RIDLE (ackout = 0):
  - req_sync = 1 and fifo_count < FIFO_DEPTH -> write datain into the FIFO tail, go to RACK.
  - req_sync = 1 and FIFO full -> remain in RIDLE with no write. This is backpressure; the transmitter stalls with reqin high.
  - req_sync = 0 -> remain in RIDLE.
- RACK (ackout = 1):
  - req_sync = 0 -> go to RIDLE.
  - Otherwise remain in RACK.
  - Exactly one write per handshake, regardless of how long reqin stays high.
- ackout is the registered decode of state == RACK, with no combinational path to the pin.
- Latency for SYNC_STAGES = 2, reqin rising just before edge k:
  - req_sync goes high after edge k+1.
  - The write and the RIDLE->RACK transition occur on edge k+2, so ackout = 1 after edge k+2.
  - If the FIFO was empty, outvalid = 1 and dataout = the word, both after edge k+2.
- Release latency: reqin falling before edge m -> ackout = 0 after edge m+2.
- FIFO read side:
  - Pop occurs on an edge where outvalid & outready.
  - dataout always shows the head word; it holds its value when outvalid = 1 and outready = 0.
  - outready while empty has no effect.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full check uses the registered count only. A pop in the same cycle does not permit a push; the push is taken one cycle later.
- Pointers wrap modulo FIFO_DEPTH. Count saturates logically at FIFO_DEPTH (never exceeded) and never underflows.
- Reset mid-handshake (state RACK):
  - ackout drops immediately and buffered words are discarded.
  - If reqin is still high after reset release, it is treated as a new request and captured again.
  - The transmitter protocol tolerates this duplicate; it is documented, not filtered.
- Unused state encodings return to RIDLE on the next edge with ackout = 0.

Test Plan:
- Single transfer: reset 1->0; datain = 32'hA5A5_0001; reqin 0->1 before edge 10; outready = 1. Required: ackout = 1 and outvalid = 1 with dataout = 32'hA5A5_0001 after edge 12. Pop on edge 13 gives fifo_count = 0. Drop reqin before edge 20 -> ackout = 0 after edge 22.
- Long request: hold reqin high for 30 cycles with outready = 1. Required: exactly one word written, fifo_count peaks at 1, ackout stays 1 until 2 cycles after reqin falls.
- Backpressure: outready = 0; five complete handshakes with data 1..5, FIFO_DEPTH = 4. Required:
  - fifo_count reaches 4; the fifth reqin sees ackout held at 0.
  - Raising outready for one cycle pops word 1; the next cycle captures word 5 and ackout rises.
  - Subsequent reads give 2, 3, 4, 5 in order.
- Wrap-around: 10 back-to-back transfers with outready toggling every cycle. Required: output order 0..9 with no loss or duplication, and fifo_count never exceeds 4.
- Simultaneous push/pop: fifo_count = 2 and a capture coincides with a pop. Required: fifo_count stays 2 and the head advances to the next word.
- Reset mid-handshake: assert reset for 1 cycle while in RACK with 3 words buffered. Required:
  - ackout, outvalid and fifo_count = 0 immediately.
  - With reqin still high, a recapture occurs 2 edges after release and fifo_count = 1.
